pipelined_decode_stage: RTL and testbench
=========================================

// Module: pipelined_decode_stage
// PURPOSE
//  Registered, multi-lane successor of the combinational decode/extend stage. Accepts LANES instructions per
//  cycle from fetch and decodes each into reservation-station select, ALU control, 32-bit immediate and
//  dispatch flags. Presents the results through a valid/ready interface to the dispatch/rename stage.
//  A 2-deep skid buffer decouples fetch from dispatch backpressure without combinational ready paths.
// PARAMETERS
//  WIDTH  31  MSB index of instruction/PC/immediate words (data width = WIDTH+1)
//  LANES  2   instructions decoded per cycle (1..4); lane 0 is oldest in program order
// PORTS
//  clk            in   1            rising-edge clock
//  resetN         in   1            asynchronous, active-low reset
//  flush          in   1            discard all buffered work (mispredict/exception)
//  inValid        in   1            fetch group present
//  inReady        out  1            stage can accept a group this cycle
//  inLaneValid    in   LANES        per-lane valid within group
//  inInstr        in   LANES*32     raw RV32I instructions
//  inPC           in   LANES*32     PC per lane
//  outValid       out  1            decoded group present
//  outReady       in   1            dispatch consumes group
//  outLaneValid   out  LANES        per-lane valid, copied from input
//  outPC          out  LANES*32     PC per lane
//  outRSstation   out  LANES*3      target reservation station (rs_sel_t)
//  outALUControl  out  LANES*4      ALU operation (alu_ctl_t)
//  outImmExt      out  LANES*32     sign/zero-extended immediate
//  outFlags       out  LANES*8      {memWrite,branch,isJAL,useImm,regWrite,isJALR,isLUI,isAUIPC}
//  outIllegal     out  LANES        (DECODE_ILLEGAL_EN only) unrecognised encoding
// BEHAVIOUR
//  - Reset: all valids (outValid, outLaneValid, skid valid) 0, inReady 1, all payload outputs 0.
//  - Latency: group accepted on cycle N (inValid&inReady) appears at output on N+1 if main register is free.
//  - Storage: main output register + one skid register. inReady = !skidValid (registered, no comb path
//    from outReady). Transfer out on outValid&outReady; skid moves to main same cycle.
//  - Accept while main full and not draining -> group goes to skid; skid full -> inReady=0 next cycle.
//  - Simultaneous accept+drain with skid empty: new group replaces main, outValid stays 1.
//  - flush: both registers invalidated next edge, inReady=1; a group presented with flush is dropped; flush
//    wins over accept and drain.
//  - Group with inValid=1 and inLaneValid=0 is accepted and discarded (never reaches output).
//  - Payload of a lane with laneValid=0 is don't-care but must not raise outIllegal.
//  - Decode per lane (opcode = instr[6:2]): OP/OP-IMM/LUI/AUIPC -> RS_ALU; BRANCH/JAL/JALR -> RS_BRANCH;
//    LOAD/STORE -> RS_LDST. Immediates per RV32I I/S/B/U/J formats.
//  - ALUControl = {funct7[5],funct3} for OP; for OP-IMM bit3 = funct7[5] only when funct3=101, else 0;
//    all other opcodes 4'b0000 (ADD).
//  - regWrite = 1 for OP,OP-IMM,LOAD,LUI,AUIPC,JAL,JALR with rd!=0; 0 otherwise. memWrite only STORE.
//    useImm = 1 for all except OP and BRANCH.
// CONFIGURATION
//  DECODE_ILLEGAL_EN defined: outIllegal[i]=1 for valid lane with instr[1:0]!=2'b11, unknown opcode or
//    reserved funct3/funct7; that lane's regWrite/memWrite forced 0, RSstation = RS_NONE.
//  Not defined: outIllegal port absent; unknown opcodes decode as RS_NONE with all flags 0.
// STRUCTURE
//  decode_pkg: opcode localparams, rs_sel_t (RS_NONE,RS_ALU,RS_BRANCH,RS_LDST), alu_ctl_t, imm_fmt_t,
//    packed struct decoded_t {rs,alu,imm,flags,pc}.
//  Sub-module decode_lane: combinational single-instruction decoder, instantiated LANES times via generate;
//    top holds only skid/handshake logic on decoded_t arrays.
// TESTING
//  1. Reset, LANES=2: lane0 0x00500093 (addi x1,x0,5), lane1 0x402081B3 (sub x3,x1,x2) -> next cycle
//     lane0 RS_ALU imm=5 useImm=1 regWrite=1 ALU=0000; lane1 RS_ALU ALU=1000 useImm=0 regWrite=1.
//  2. 0x0020A423 (sw x2,8(x1)) -> RS_LDST memWrite=1 regWrite=0 imm=8; 0xFE000EE3 (beq -4) -> RS_BRANCH
//     branch=1 imm=0xFFFFFFFC; 0x123452B7 (lui x5) -> isLUI=1 imm=0x12345000.
//  3. Hold outReady=0, push 3 groups -> first two accepted, inReady=0 on third; raise outReady -> groups
//     drained in order G0,G1 on consecutive cycles, then G2 accepted.
//  4. Both registers full, assert flush with inValid=1 -> next cycle outValid=0, inReady=1, no group emitted.
//  5. addi x0,x0,0 (0x00000013) -> regWrite=0; resetN pulsed low mid-stall -> outputs cleared immediately.
//  6. DECODE_ILLEGAL_EN: 0x00000000 on lane1 -> outIllegal=2'b10, lane1 RS_NONE, lane0 decoded normally.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32I decode types, opcode constants and immediate extraction
// Used by decode_lane and pipelined_decode_stage. No ports.
package decode_pkg;
    localparam int XLEN = 32;
    // Major opcodes, instr[6:2]; OPC_BAD tags encodings whose instr[1:0] is not 2'b11
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_BAD    = 5'b11111;
    typedef enum logic [2:0] {RS_NONE, RS_ALU, RS_BRANCH, RS_LDST} rs_sel_t;
    typedef logic [3:0] alu_ctl_t;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
    typedef struct packed {
        logic mem_write;
        logic branch;
        logic is_jal;
        logic use_imm;
        logic reg_write;
        logic is_jalr;
        logic is_lui;
        logic is_auipc;
    } flags_t;
    typedef struct packed {
        rs_sel_t         rs;
        alu_ctl_t        alu;
        logic [XLEN-1:0] imm;
        flags_t          flags;
        logic [XLEN-1:0] pc;
    } decoded_t;
    function automatic logic [XLEN-1:0] ext_imm(input logic [XLEN-1:0] i, input imm_fmt_t f);
        return f == IMM_I ? {{20{i[31]}}, i[31:20]} :
               f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
               f == IMM_U ? {i[31:12], 12'b0} :
               f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : '0;
    endfunction
endpackage

// File: rtl/decode_lane.sv
// decode_lane: combinational decoder for one RV32I instruction
// Ports: instr/pc in; d = decoded_t {rs, alu, imm, flags, pc};
// illegal out only when DECODE_ILLEGAL_EN is defined.
module decode_lane
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output decoded_t        d
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);
    logic [4:0] opc;
    logic [2:0] f3;
    imm_fmt_t   fmt;
    assign opc = instr[1:0] == 2'b11 ? instr[6:2] : OPC_BAD;
    assign f3  = instr[14:12];
    always_comb begin
        d = '0;
        d.pc = pc;
        fmt = IMM_NONE;
        case (opc)
            OPC_OP:     begin d.rs = RS_ALU; d.alu = {instr[30], f3}; end
            OPC_OP_IMM: begin d.rs = RS_ALU; d.alu = {f3 == 3'b101 && instr[30], f3}; fmt = IMM_I; end
            OPC_LUI:    begin d.rs = RS_ALU; fmt = IMM_U; d.flags.is_lui = 1'b1; end
            OPC_AUIPC:  begin d.rs = RS_ALU; fmt = IMM_U; d.flags.is_auipc = 1'b1; end
            OPC_BRANCH: begin d.rs = RS_BRANCH; fmt = IMM_B; d.flags.branch = 1'b1; end
            OPC_JAL:    begin d.rs = RS_BRANCH; fmt = IMM_J; d.flags.is_jal = 1'b1; end
            OPC_JALR:   begin d.rs = RS_BRANCH; fmt = IMM_I; d.flags.is_jalr = 1'b1; end
            OPC_LOAD:   begin d.rs = RS_LDST; fmt = IMM_I; end
            OPC_STORE:  begin d.rs = RS_LDST; fmt = IMM_S; d.flags.mem_write = 1'b1; end
            default:    ;
        endcase
        d.imm = ext_imm(instr, fmt);
        d.flags.use_imm = d.rs != RS_NONE && opc != OPC_OP && opc != OPC_BRANCH;
        d.flags.reg_write = d.rs != RS_NONE && opc != OPC_STORE && opc != OPC_BRANCH && instr[11:7] != 5'd0;
`ifdef DECODE_ILLEGAL_EN
        // Unknown opcode, or a funct3/funct7 combination RV32I leaves reserved
        illegal = d.rs == RS_NONE ||
                  (opc == OPC_OP && !(instr[31:25] == 7'h00 || (instr[31:25] == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) ||
                  (opc == OPC_OP_IMM && f3 == 3'b001 && instr[31:25] != 7'h00) ||
                  (opc == OPC_OP_IMM && f3 == 3'b101 && instr[31:25] != 7'h00 && instr[31:25] != 7'h20) ||
                  (opc == OPC_LOAD && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
                  (opc == OPC_STORE && f3 > 3'b010) ||
                  (opc == OPC_BRANCH && (f3 == 3'b010 || f3 == 3'b011)) ||
                  (opc == OPC_JALR && f3 != 3'b000);
        if (illegal) begin
            d.rs = RS_NONE;
            d.flags.reg_write = 1'b0;
            d.flags.mem_write = 1'b0;
        end
`endif
    end
endmodule

// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: multi-lane registered RV32I decode with a 2-entry skid buffer
// Ports: clk, resetN (async active-low), flush; fetch side inValid/inReady/inLaneValid/inInstr/inPC;
// dispatch side outValid/outReady/outLaneValid/outPC/outRSstation/outALUControl/outImmExt/outFlags.
// Optional macro DECODE_ILLEGAL_EN adds outIllegal (per-lane unrecognised encoding).
module pipelined_decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       flush,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [LANES-1:0]           inLaneValid,
    input  logic [LANES*(WIDTH+1)-1:0] inInstr,
    input  logic [LANES*(WIDTH+1)-1:0] inPC,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [LANES-1:0]           outLaneValid,
    output logic [LANES*(WIDTH+1)-1:0] outPC,
    output logic [LANES*3-1:0]         outRSstation,
    output logic [LANES*4-1:0]         outALUControl,
    output logic [LANES*(WIDTH+1)-1:0] outImmExt,
`ifdef DECODE_ILLEGAL_EN
    output logic [LANES-1:0]           outIllegal,
`endif
    output logic [LANES*8-1:0]         outFlags
);
    localparam int W = WIDTH + 1;
    decoded_t [LANES-1:0] dec, main_q, skid_q;
    logic [LANES-1:0] main_lv, skid_lv;
    logic main_v, skid_v, accept, drain, load_main_in, load_main_skid, load_skid;
    // inReady depends only on state, so dispatch backpressure never reaches fetch combinationally
    assign inReady = !skid_v;
    assign outValid = main_v;
    // Groups with no valid lane are taken but never stored
    assign accept = inValid && inReady && |inLaneValid && !flush;
    assign drain = main_v && outReady;
    assign load_main_in = accept && (drain || !main_v);
    assign load_main_skid = drain && skid_v;
    assign load_skid = accept && main_v && !drain;
    assign outLaneValid = main_lv & {LANES{main_v}};
`ifdef DECODE_ILLEGAL_EN
    logic [LANES-1:0] ill, main_ill, skid_ill;
`endif
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_lane u_dec (
            .instr(inInstr[i*W +: W]),
            .pc(inPC[i*W +: W]),
`ifdef DECODE_ILLEGAL_EN
            .illegal(ill[i]),
`endif
            .d(dec[i])
        );
        assign outPC[i*W +: W]         = main_q[i].pc;
        assign outRSstation[i*3 +: 3]  = main_q[i].rs;
        assign outALUControl[i*4 +: 4] = main_q[i].alu;
        assign outImmExt[i*W +: W]     = main_q[i].imm;
        assign outFlags[i*8 +: 8]      = main_q[i].flags;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
            main_lv <= '0;
            skid_lv <= '0;
        end else begin
            main_v <= !flush && (drain ? skid_v || accept : main_v || accept);
            skid_v <= !flush && (load_skid || (skid_v && !drain));
            if (load_main_in) begin
                main_q  <= dec;
                main_lv <= inLaneValid;
            end else if (load_main_skid) begin
                main_q  <= skid_q;
                main_lv <= skid_lv;
            end
            if (load_skid) begin
                skid_q  <= dec;
                skid_lv <= inLaneValid;
            end
        end
    end
`ifdef DECODE_ILLEGAL_EN
    // Invalid lanes never report illegal, whatever their payload
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            main_ill <= '0;
            skid_ill <= '0;
        end else begin
            if (load_main_in) main_ill <= ill & inLaneValid;
            else if (load_main_skid) main_ill <= skid_ill;
            if (load_skid) skid_ill <= ill & inLaneValid;
        end
    end
    assign outIllegal = main_ill & outLaneValid;
`endif
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// tb_pipelined_decode_stage: directed vectors checked against a group-FIFO decode model
module tb_pipelined_decode_stage;
    localparam int LANES = 2;
    localparam int W = 32;
    localparam logic [7:0] MW = 8'h80, BR = 8'h40, JL = 8'h20, UI = 8'h10;
    localparam logic [7:0] RW = 8'h08, JR = 8'h04, LU = 8'h02, AU = 8'h01;

    logic clk = 1'b0, resetN = 1'b0, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic inReady, outValid;
    logic [LANES-1:0] inLaneValid = '0;
    logic [LANES-1:0] outLaneValid;
    logic [LANES*W-1:0] inInstr = '0;
    logic [LANES*W-1:0] inPC = '0;
    logic [LANES*W-1:0] outPC, outImmExt;
    logic [LANES*3-1:0] outRSstation;
    logic [LANES*4-1:0] outALUControl;
    logic [LANES*8-1:0] outFlags;
`ifdef DECODE_ILLEGAL_EN
    logic [LANES-1:0] outIllegal;
`endif
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [LANES-1:0]   lv;
        logic [LANES*W-1:0] instr;
        logic [LANES*W-1:0] pc;
    } grp_t;
    grp_t q[$];

    typedef struct packed {
        logic [2:0]  rs;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [7:0]  fl;
        logic        ill;
    } exp_t;

    always #5 clk = ~clk;

    pipelined_decode_stage #(.WIDTH(31), .LANES(LANES)) dut (
        .clk(clk),
        .resetN(resetN),
        .flush(flush),
        .inValid(inValid),
        .inReady(inReady),
        .inLaneValid(inLaneValid),
        .inInstr(inInstr),
        .inPC(inPC),
        .outValid(outValid),
        .outReady(outReady),
        .outLaneValid(outLaneValid),
        .outPC(outPC),
        .outRSstation(outRSstation),
        .outALUControl(outALUControl),
        .outImmExt(outImmExt),
`ifdef DECODE_ILLEGAL_EN
        .outIllegal(outIllegal),
`endif
        .outFlags(outFlags)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Decode straight from the RV32I tables: 7-bit opcode, immediates via arithmetic shifts and masks
    function automatic exp_t model(input logic [31:0] x);
        exp_t e;
        int s, t20, t19, t11;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] rw;
        logic legal;
        s = x;
        t20 = s >>> 20;
        t19 = s >>> 19;
        t11 = s >>> 11;
        f3 = x[14:12];
        f7 = x[31:25];
        rw = x[11:7] != 5'd0 ? RW : 8'h00;
        e = '0;
        legal = 1'b1;
        case (x[6:0])
            7'h33: begin e.rs = 3'd1; e.alu = {f7[5], f3}; e.fl = rw;
                   legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
            7'h13: begin e.rs = 3'd1; e.alu = {f3 == 3'd5 && f7[5], f3}; e.imm = t20; e.fl = UI | rw;
                   legal = f3 == 3'd1 ? f7 == 7'h00 : (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20); end
            7'h37: begin e.rs = 3'd1; e.imm = x & 32'hFFFFF000; e.fl = UI | rw | LU; end
            7'h17: begin e.rs = 3'd1; e.imm = x & 32'hFFFFF000; e.fl = UI | rw | AU; end
            7'h63: begin e.rs = 3'd2; e.imm = (t19 & 32'hFFFFF000) | {20'h0, x[7], x[30:25], x[11:8], 1'b0};
                   e.fl = BR; legal = f3 != 3'd2 && f3 != 3'd3; end
            7'h6F: begin e.rs = 3'd2; e.fl = JL | UI | rw;
                   e.imm = (t11 & 32'hFFF00000) | (x & 32'h000FF000) | {20'h0, x[20], x[30:21], 1'b0}; end
            7'h67: begin e.rs = 3'd2; e.imm = t20; e.fl = JR | UI | rw; legal = f3 == 3'd0; end
            7'h03: begin e.rs = 3'd3; e.imm = t20; e.fl = UI | rw; legal = f3 != 3'd3 && f3 < 3'd6; end
            7'h23: begin e.rs = 3'd3; e.imm = (t20 & ~32'h1F) | {27'h0, x[11:7]}; e.fl = MW | UI;
                   legal = f3 < 3'd3; end
            default: legal = 1'b0;
        endcase
        e.ill = !legal;
`ifdef DECODE_ILLEGAL_EN
        if (!legal) begin
            e.rs = 3'd0;
            e.fl = e.fl & ~(MW | RW);
        end
`endif
        return e;
    endfunction

    // Reference: the stage is a FIFO of at most two groups, flushed by flush or reset
    always @(posedge clk or negedge resetN) begin
        if (!resetN || flush) q.delete();
        else begin
            automatic logic acc = inValid && q.size() < 2 && |inLaneValid;
            if (outReady && q.size() != 0) q.delete(0);
            if (acc) q.push_back('{inLaneValid, inInstr, inPC});
        end
    end

    always @(negedge clk) begin
`ifdef DECODE_ILLEGAL_EN
        automatic logic [LANES-1:0] ill_exp = '0;
`endif
        chk("outValid", outValid, q.size() != 0);
        chk("inReady", inReady, q.size() < 2);
        chk("outLaneValid", outLaneValid, q.size() != 0 ? q[0].lv : '0);
        if (!resetN) begin
            chk("reset outPC", outPC, '0);
            chk("reset outImmExt", outImmExt, '0);
            chk("reset outFlags", outFlags, '0);
            chk("reset outRSstation", outRSstation, '0);
            chk("reset outALUControl", outALUControl, '0);
        end
        if (q.size() != 0)
            for (int l = 0; l < LANES; l++)
                if (q[0].lv[l]) begin
                    automatic exp_t e = model(q[0].instr[l*W +: W]);
                    chk($sformatf("rs lane%0d", l), outRSstation[l*3 +: 3], e.rs);
                    chk($sformatf("alu lane%0d", l), outALUControl[l*4 +: 4], e.alu);
                    chk($sformatf("imm lane%0d", l), outImmExt[l*W +: W], e.imm);
                    chk($sformatf("flags lane%0d", l), outFlags[l*8 +: 8], e.fl);
                    chk($sformatf("pc lane%0d", l), outPC[l*W +: W], q[0].pc[l*W +: W]);
`ifdef DECODE_ILLEGAL_EN
                    ill_exp[l] = e.ill;
`endif
                end
`ifdef DECODE_ILLEGAL_EN
        chk("outIllegal", outIllegal, ill_exp);
`endif
    end

    task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] i1, input logic [31:0] i0,
                         input logic [31:0] p0);
        inValid = v;
        inLaneValid = lv;
        inInstr = {i1, i0};
        inPC = {p0 + 32'd4, p0};
    endtask

    initial begin
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        outReady = 1'b1;
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h100);
        @(negedge clk);
        chk("t1 rs0", outRSstation[2:0], 3'd1);
        chk("t1 imm0", outImmExt[31:0], 32'd5);
        chk("t1 flags0", outFlags[7:0], 8'h18);
        chk("t1 alu0", outALUControl[3:0], 4'b0000);
        chk("t1 rs1", outRSstation[5:3], 3'd1);
        chk("t1 alu1", outALUControl[7:4], 4'b1000);
        chk("t1 flags1", outFlags[15:8], 8'h08);
        chk("t1 pc1", outPC[63:32], 32'h104);
        drive(1, 2'b11, 32'hFE000EE3, 32'h0020A423, 32'h200);
        @(negedge clk);
        chk("sw rs", outRSstation[2:0], 3'd3);
        chk("sw flags", outFlags[7:0], 8'h90);
        chk("sw imm", outImmExt[31:0], 32'd8);
        chk("beq rs", outRSstation[5:3], 3'd2);
        chk("beq flags", outFlags[15:8], 8'h40);
        chk("beq imm", outImmExt[63:32], 32'hFFFFFFFC);
        drive(1, 2'b11, 32'h010000EF, 32'h123452B7, 32'h300);
        @(negedge clk);
        chk("lui flags", outFlags[7:0], 8'h1A);
        chk("lui imm", outImmExt[31:0], 32'h12345000);
        chk("jal flags", outFlags[15:8], 8'h38);
        chk("jal imm", outImmExt[63:32], 32'd16);
        drive(1, 2'b01, 32'h00000000, 32'h00000013, 32'h380);
        @(negedge clk);
        chk("nop flags", outFlags[7:0], 8'h10);
        chk("nop lanevalid", outLaneValid, 2'b01);
        drive(0, 2'b00, 0, 0, 0);
        @(negedge clk);
        outReady = 1'b0;
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h400);
        @(negedge clk);
        chk("stall ready g1", inReady, 1'b1);
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h500);
        @(negedge clk);
        chk("stall ready g2", inReady, 1'b0);
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h600);
        @(negedge clk);
        chk("stall hold pc", outPC[31:0], 32'h400);
        chk("stall hold ready", inReady, 1'b0);
        outReady = 1'b1;
        @(negedge clk);
        chk("drain g1 pc", outPC[31:0], 32'h500);
        @(negedge clk);
        chk("drain g2 pc", outPC[31:0], 32'h600);
        drive(0, 2'b00, 0, 0, 0);
        @(negedge clk);
        chk("drained", outValid, 1'b0);
        outReady = 1'b0;
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h700);
        @(negedge clk);
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h800);
        @(negedge clk);
        chk("full before flush", outValid, 1'b1);
        flush = 1'b1;
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h900);
        @(negedge clk);
        chk("flush valid", outValid, 1'b0);
        chk("flush ready", inReady, 1'b1);
        flush = 1'b0;
        drive(0, 2'b00, 0, 0, 0);
        @(negedge clk);
        chk("post flush", outValid, 1'b0);
        flush = 1'b1;
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'h980);
        @(negedge clk);
        chk("flush drops input", outValid, 1'b0);
        flush = 1'b0;
        drive(1, 2'b00, 32'h402081B3, 32'h00500093, 32'h990);
        @(negedge clk);
        chk("empty group", outValid, 1'b0);
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'hA00);
        @(negedge clk);
        drive(1, 2'b11, 32'h402081B3, 32'h00500093, 32'hB00);
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0);
        #2 resetN = 1'b0;
        #1;
        chk("async rst valid", outValid, 1'b0);
        chk("async rst ready", inReady, 1'b1);
        chk("async rst pc", outPC, '0);
        chk("async rst flags", outFlags, '0);
        @(negedge clk);
        resetN = 1'b1;
        outReady = 1'b1;
        drive(1, 2'b11, 32'h00000000, 32'h00500093, 32'hC00);
        @(negedge clk);
        chk("bad lane rs", outRSstation[5:3], 3'd0);
        chk("good lane rs", outRSstation[2:0], 3'd1);
        chk("good lane imm", outImmExt[31:0], 32'd5);
`ifdef DECODE_ILLEGAL_EN
        chk("illegal lane1", outIllegal, 2'b10);
`endif
        drive(1, 2'b01, 32'h00000000, 32'h00500093, 32'hD00);
        @(negedge clk);
`ifdef DECODE_ILLEGAL_EN
        chk("invalid lane not illegal", outIllegal, 2'b00);
`endif
        drive(1, 2'b11, 32'h0040A103, 32'h00003083, 32'hE00);
        @(negedge clk);
        drive(1, 2'b11, 32'h00001517, 32'h000080E7, 32'hF00);
        @(negedge clk);
        drive(1, 2'b11, 32'h0000A0E7, 32'h4020D093, 32'h1000);
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
